pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_if.sv | 11 +
 rtl/pc_fetch_ctrl_redir_arb.sv | 91 +++++++++
 rtl/pc_fetch_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC fetch controller (package pc_pkg).
// Optional EPC/ERET support in the controller is enabled by defining PC_FETCH_EPC_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } pc_state_e;

    // Ordered so that a numeric compare gives redirect priority.
    typedef enum logic [1:0] {
        PRI_NONE  = 2'd0,
        PRI_REDIR = 2'd1,
        PRI_ERET  = 2'd2,
        PRI_EXC   = 2'd3
    } redir_pri_e;

    localparam int unsigned PC_INC           = 32'd4;
    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between the fetch controller and imem.
interface pc_fetch_ctrl_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_ctrl_redir_arb.sv
// Redirect arbiter: ranks live exc/eret/redir requests and holds a pending one
// across memory wait states. eret/epc ports exist only with PC_FETCH_EPC_EN.
module pc_redir_arb
    import pc_pkg::*;
#(
    parameter int            AW      = 32,
    parameter logic [AW-1:0] EXC_VEC = AW'(PC_EXC_VEC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exc_i,
`ifdef PC_FETCH_EPC_EN
    input  logic          eret_i,
    input  logic [AW-1:0] epc_i,
`endif
    input  logic          redir_valid_i,
    input  logic [AW-1:0] redir_pc_i,
    input  logic          hold_i,
    input  logic          clear_i,
    output logic          take_valid_o,
    output logic [AW-1:0] take_target_o
);

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    redir_pri_e    live_pri_s;
    redir_pri_e    win_pri_s;
    redir_pri_e    pend_pri_q;
    redir_pri_e    pend_pri_d;
    logic [AW-1:0] live_tgt_s;
    logic [AW-1:0] win_tgt_s;
    logic [AW-1:0] pend_tgt_q;
    logic [AW-1:0] pend_tgt_d;

    // Classify this cycle's request; exc outranks everything.
    always_comb begin
        live_pri_s = PRI_NONE;
        live_tgt_s = redir_pc_i & ALIGN_MASK;
        if (exc_i) begin
            live_pri_s = PRI_EXC;
            live_tgt_s = EXC_VEC & ALIGN_MASK;
        end
`ifdef PC_FETCH_EPC_EN
        else if (eret_i) begin
            live_pri_s = PRI_ERET;
            live_tgt_s = epc_i & ALIGN_MASK;
        end
`endif
        else if (redir_valid_i) begin
            live_pri_s = PRI_REDIR;
        end else begin
            live_pri_s = PRI_NONE;
        end
    end

    // Live request wins ties so equal priority is newest-wins.
    always_comb begin
        if ((live_pri_s != PRI_NONE) && (live_pri_s >= pend_pri_q)) begin
            win_pri_s = live_pri_s;
            win_tgt_s = live_tgt_s;
        end else begin
            win_pri_s = pend_pri_q;
            win_tgt_s = pend_tgt_q;
        end
        if (clear_i) begin
            pend_pri_d = PRI_NONE;
            pend_tgt_d = pend_tgt_q;
        end else if (hold_i) begin
            pend_pri_d = win_pri_s;
            pend_tgt_d = win_tgt_s;
        end else begin
            pend_pri_d = pend_pri_q;
            pend_tgt_d = pend_tgt_q;
        end
    end

    // Pending redirect storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pri_q <= PRI_NONE;
            pend_tgt_q <= {AW{1'b0}};
        end else begin
            pend_pri_q <= pend_pri_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign take_valid_o  = (win_pri_s != PRI_NONE);
    assign take_target_o = win_tgt_s;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: BOOT/REQ/STALL sequencing of instruction fetches with redirects.
// Define PC_FETCH_EPC_EN to add eret input and epc output.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC_DEF),
    parameter logic [AW-1:0] EXC_VEC   = AW'(PC_EXC_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redir_valid,
    input  logic [AW-1:0]   redir_pc,
    input  logic            exc,
`ifdef PC_FETCH_EPC_EN
    input  logic            eret,
    output logic [AW-1:0]   epc,
`endif
    pc_fetch_ctrl_if.master imem,
    output logic [AW-1:0]   pc,
    output logic            pc_valid
);

    pc_state_e     state_q;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] pc_q;
    logic          pc_valid_q;
    logic          imem_req_q;
    logic          hold_s;
    logic          clear_s;
    logic          take_valid_s;
    logic [AW-1:0] take_target_s;

    assign hold_s  = (state_q == ST_REQ) && !imem.imem_ack;
    assign clear_s = (state_q == ST_REQ) &&  imem.imem_ack;

`ifdef PC_FETCH_EPC_EN
    logic [AW-1:0] epc_q;

    // Capture the last delivered pc whenever an exception is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= RESET_VEC;
        end else if (exc) begin
            epc_q <= pc_q;
        end else begin
            epc_q <= epc_q;
        end
    end

    assign epc = epc_q;
`endif

    pc_redir_arb #(
        .AW      (AW),
        .EXC_VEC (EXC_VEC)
    ) u_redir_arb (
        .clk           (clk),
        .rst           (rst),
        .exc_i         (exc),
`ifdef PC_FETCH_EPC_EN
        .eret_i        (eret),
        .epc_i         (epc_q),
`endif
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .hold_i        (hold_s),
        .clear_i       (clear_s),
        .take_valid_o  (take_valid_s),
        .take_target_o (take_target_s)
    );

    // Fetch FSM with registered request, fetch address and delivered pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_VEC;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            pc_valid_q <= 1'b0;
            case (state_q)
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        if (take_valid_s) begin
                            fetch_pc_q <= take_target_s;
                        end else begin
                            pc_q       <= fetch_pc_q;
                            pc_valid_q <= 1'b1;
                            fetch_pc_q <= fetch_pc_q + AW'(PC_INC);
                        end
                        state_q    <= stall ? ST_STALL : ST_REQ;
                        imem_req_q <= !stall;
                    end else begin
                        state_q    <= ST_REQ;
                        imem_req_q <= 1'b1;
                    end
                end
                ST_BOOT, ST_STALL: begin
                    // Nothing outstanding here, so redirects load directly.
                    if (take_valid_s) begin
                        fetch_pc_q <= take_target_s;
                    end else begin
                        fetch_pc_q <= fetch_pc_q;
                    end
                    state_q    <= stall ? ST_STALL : ST_REQ;
                    imem_req_q <= !stall;
                end
                default: begin
                    state_q    <= ST_BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = fetch_pc_q;
    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;

endmodule
